// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: FSM encoding, default
// frame header and the bytes-per-register calculation.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
  localparam int         MAX_REG_W    = 32;

  function automatic int calc_bpr(input int reg_w);
    return (reg_w + 7) / 8;
  endfunction

endpackage

// File: rtl/reg_dump_snap.sv
// Coherent snapshot of the register file plus a registered byte selector
// that presents one byte of the snapshot per cycle.
module reg_dump_snap
  import reg_dump_pkg::*;
#(
  parameter int NREG  = 37,
  parameter int REG_W = 16,
  parameter int RIW   = 6
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic [NREG*REG_W-1:0]   regs_flat,
  input  logic [RIW-1:0]          reg_sel,
  input  logic [1:0]              byte_sel,
  output logic [7:0]              byte_out
);

  logic [REG_W-1:0]     snap [NREG];
  logic [MAX_REG_W-1:0] word;

  // Zero-extend the selected register so the upper bytes read as 0.
  always_comb word = MAX_REG_W'(snap[reg_sel]);

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NREG; i++) begin
        snap[i] <= regs_flat[i*REG_W +: REG_W];
      end
    end
    byte_out <= word[{byte_sel, 3'b000} +: 8];
  end

endmodule

// File: rtl/reg_dump_stream.sv
// Debug register dump engine: snapshots NREG registers on start and streams
// a framed byte sequence (header, count, payload MSB-first, checksum).
module reg_dump_stream
  import reg_dump_pkg::*;
#(
  parameter int         NREG     = 37,
  parameter int         REG_W    = 16,
  parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE,
  parameter bit         CSUM_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NREG*REG_W-1:0] regs_flat,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int             BPR      = calc_bpr(REG_W);
  localparam int             RIW      = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [RIW-1:0] LAST_REG = RIW'(NREG - 1);
  localparam logic [1:0]     TOP_BYTE = 2'(BPR - 1);
  localparam logic [7:0]     COUNT    = 8'(NREG);

  state_t         state, state_nxt;
  logic [RIW-1:0] reg_idx, reg_idx_nxt;
  logic [1:0]     byte_idx, byte_idx_nxt;
  logic [7:0]     csum, csum_nxt;
  logic           done_nxt;
  logic           load;
  logic           xfer;
  logic [7:0]     snap_byte;

  reg_dump_snap #(
    .NREG  (NREG),
    .REG_W (REG_W),
    .RIW   (RIW)
  ) u_snap (
    .clk       (clk),
    .load      (load),
    .regs_flat (regs_flat),
    .reg_sel   (reg_idx_nxt),
    .byte_sel  (byte_idx_nxt),
    .byte_out  (snap_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      reg_idx  <= '0;
      byte_idx <= '0;
      csum     <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      reg_idx  <= reg_idx_nxt;
      byte_idx <= byte_idx_nxt;
      csum     <= csum_nxt;
      done     <= done_nxt;
    end
  end

  // Outputs decode straight from registered state so they hold during stalls.
  always_comb begin
    out_valid = (state != ST_IDLE);
    busy      = out_valid;
    case (state)
      ST_HDR:  out_data = HDR_BYTE;
      ST_LEN:  out_data = COUNT;
      ST_DATA: out_data = snap_byte;
      ST_CSUM: out_data = 8'h00 - csum;
      default: out_data = 8'h00;
    endcase
  end

  assign xfer = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    reg_idx_nxt  = reg_idx;
    byte_idx_nxt = byte_idx;
    csum_nxt     = csum;
    done_nxt     = 1'b0;
    load         = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        load         = 1'b1;
        csum_nxt     = '0;
        reg_idx_nxt  = '0;
        byte_idx_nxt = TOP_BYTE;
        state_nxt    = ST_HDR;
      end
    end else if (abort) begin
      state_nxt = ST_IDLE;
    end else if (xfer) begin
      csum_nxt = csum + out_data;
      case (state)
        ST_HDR: state_nxt = ST_LEN;
        ST_LEN: state_nxt = ST_DATA;
        ST_DATA: begin
          if (byte_idx != 2'd0) begin
            byte_idx_nxt = byte_idx - 2'd1;
          end else if (reg_idx != LAST_REG) begin
            reg_idx_nxt  = reg_idx + 1'b1;
            byte_idx_nxt = TOP_BYTE;
          end else if (CSUM_EN) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_stream.sv
// Self-checking bench for reg_dump_stream: table-driven frames, random frames
// against a frame-building model, and hand-written abort/reset/stall sequences.
module tb_reg_dump_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, abort_a, ready_a;
  logic [31:0] regs_a;
  logic [7:0]  data_a;
  logic        valid_a, busy_a, done_a;

  logic        start_b, abort_b, ready_b;
  logic [35:0] regs_b;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, done_b;

  reg_dump_stream #(.NREG(2), .REG_W(16), .HDR_BYTE(8'hA5), .CSUM_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .regs_flat(regs_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a), .done(done_a));

  reg_dump_stream #(.NREG(3), .REG_W(12), .HDR_BYTE(8'hA5), .CSUM_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .regs_flat(regs_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b), .done(done_b));

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_c, last_x, busy_c;

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r1;
    int          mode;
    logic [7:0]  exp [7];
    int          exp_busy;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame for the NREG=2, REG_W=16 instance, built from the frame rules.
  function automatic void model_a(input logic [31:0] regs);
    int sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'd2);
    for (int r = 0; r < 2; r++)
      for (int b = 1; b >= 0; b--)
        exp_q.push_back(8'((regs >> (16 * r + 8 * b)) & 32'hFF));
    foreach (exp_q[i]) sum += int'(exp_q[i]);
    exp_q.push_back(8'((256 - sum % 256) % 256));
  endfunction

  // mode 0: ready always 1; 1: ready toggles; other: random ready.
  task automatic frame_a(input logic [31:0] regs, input int mode, input int abort_at,
                         input bit chg, input bit start_busy);
    int cyc = 0;
    int nx = 0;
    bit stall = 0;
    bit fin = 0;
    logic [7:0] held = 8'h00;
    got.delete();
    done_c = -1; last_x = -10; busy_c = 0;
    regs_a = regs;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    if (chg) regs_a = $urandom;
    while (!fin && cyc < 200) begin
      abort_a = 1'b0;
      start_a = 1'b0;
      if (done_a) begin
        done_c = cyc;
        fin = 1;
      end else if (!busy_a) begin
        fin = 1;
      end else begin
        busy_c++;
        if (stall) chk("stall_hold", 32'(data_a), 32'(held));
        case (mode)
          0:       ready_a = 1'b1;
          1:       ready_a = (cyc % 2 == 0);
          default: ready_a = 1'($urandom_range(0, 1));
        endcase
        if (start_busy && cyc == 3) start_a = 1'b1;
        if (valid_a && ready_a) begin
          nx++;
          if (nx == abort_at) abort_a = 1'b1;
          else got.push_back(data_a);
          last_x = cyc;
        end
        stall = valid_a && !ready_a;
        held  = data_a;
        if (chg) regs_a = $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("frame_timeout", 32'd0, 32'd1);
    abort_a = 1'b0;
    start_a = 1'b0;
  endtask

  task automatic cmp_exp(input string tag);
    int s = 0;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      chk({tag, "_byte"}, (j < got.size()) ? 32'(got[j]) : 32'hDEAD, 32'(exp_q[j]));
    chk({tag, "_done_lat"}, 32'(done_c), 32'(last_x + 1));
    foreach (got[j]) s += int'(got[j]);
    chk({tag, "_sum"}, 32'(s % 256), 32'd0);
  endtask

  logic [7:0] exp_b [8];

  initial begin
    tbl[0] = '{r0: 16'h1234, r1: 16'hABCD, mode: 0,
               exp: '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h9B}, exp_busy: 7};
    tbl[1] = '{r0: 16'h1234, r1: 16'hABCD, mode: 1,
               exp: '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h9B}, exp_busy: -1};
    tbl[2] = '{r0: 16'h0000, r1: 16'h0000, mode: 0,
               exp: '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59}, exp_busy: 7};
    tbl[3] = '{r0: 16'hFFFF, r1: 16'h0001, mode: 0,
               exp: '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h5A}, exp_busy: 7};
    exp_b = '{8'hA5, 8'h03, 8'h0A, 8'hBC, 8'h00, 8'h01, 8'h0F, 8'hFF};

    reset = 1'b1;
    start_a = 0; abort_a = 0; ready_a = 0; regs_a = '0;
    start_b = 0; abort_b = 0; ready_b = 0; regs_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data",  32'(data_a),  32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      exp_q.delete();
      for (int j = 0; j < 7; j++) exp_q.push_back(tbl[i].exp[j]);
      frame_a({tbl[i].r1, tbl[i].r0}, tbl[i].mode, 0, 1'b0, 1'b0);
      cmp_exp("tbl");
      if (tbl[i].exp_busy > 0) chk("tbl_busy_cycles", 32'(busy_c), 32'(tbl[i].exp_busy));
      @(negedge clk);
      chk("tbl_done_one_cycle", 32'(done_a), 32'd0);
    end

    // Three 12-bit registers, no checksum byte.
    regs_b = {12'hFFF, 12'h001, 12'hABC};
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ready_b = 1'b1;
    begin
      logic [7:0] gb[$];
      int dc = -1;
      for (int c = 0; c < 30 && dc < 0; c++) begin
        if (done_b) dc = c;
        else begin
          if (valid_b) gb.push_back(data_b);
          @(negedge clk);
        end
      end
      chk("b_len", 32'(gb.size()), 32'd8);
      for (int j = 0; j < 8; j++)
        chk("b_byte", (j < gb.size()) ? 32'(gb[j]) : 32'hDEAD, 32'(exp_b[j]));
      chk("b_done_cycle", 32'(dc), 32'd8);
    end
    ready_b = 1'b0;

    // Abort on the 4th transfer, then a clean frame.
    frame_a(32'hABCD_1234, 0, 4, 1'b0, 1'b0);
    chk("abort_no_done", 32'(done_c), 32'hFFFF_FFFF);
    chk("abort_busy",    32'(busy_a), 32'd0);
    chk("abort_valid",   32'(valid_a), 32'd0);
    chk("abort_kept",    32'(got.size()), 32'd3);
    model_a(32'h5A5A_0F0F);
    frame_a(32'h5A5A_0F0F, 0, 0, 1'b0, 1'b0);
    cmp_exp("after_abort");

    // Reset in the middle of the payload.
    regs_a = 32'hCAFE_BEEF;
    start_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", 32'(valid_a), 32'd0);
    chk("midrst_data",  32'(data_a),  32'd0);
    chk("midrst_busy",  32'(busy_a),  32'd0);
    chk("midrst_done",  32'(done_a),  32'd0);
    @(negedge clk);
    chk("midrst_no_done", 32'(done_a), 32'd0);

    // start while busy is ignored.
    model_a(32'h0102_0304);
    frame_a(32'h0102_0304, 0, 0, 1'b0, 1'b1);
    cmp_exp("start_busy");
    @(negedge clk);
    chk("start_busy_idle", 32'(busy_a), 32'd0);

    // Random frames, random back-pressure, regs changing after the start edge.
    for (int k = 0; k < 20; k++) begin
      logic [31:0] r;
      r = $urandom;
      model_a(r);
      frame_a(r, 2, 0, 1'($urandom_range(0, 1)), 1'b0);
      cmp_exp("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
